// File: rtl/ss2_target_mux.sv
// SimpleSerial2 byte-bus bridge: decodes the host address MSBs into one of
// pNUM_TARGETS register-file channels plus a reserved bridge status register.

module ss2_target_lane (
  input  logic wr_act,
  input  logic rd_act,
  output logic cen,
  output logic rdn,
  output logic wrn
);
  assign cen = ~(wr_act | rd_act);
  assign rdn = ~rd_act;
  assign wrn = ~wr_act;
endmodule

module ss2_target_mux #(
  parameter int pADDR_WIDTH  = 32,
  parameter int pSEL_BITS    = 2,
  parameter int pNUM_TARGETS = 2,
  parameter int pRD_LATENCY  = 2
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic [pADDR_WIDTH-1:0]            host_addr,
  input  logic [7:0]                        host_wdata,
  output logic [7:0]                        host_rdata,
  input  logic                              host_rdn,
  input  logic                              host_wrn,
  input  logic                              host_cen,
  output logic [pADDR_WIDTH-pSEL_BITS-1:0]  tgt_addr,
  output logic [7:0]                        tgt_wdata,
  input  logic [8*pNUM_TARGETS-1:0]         tgt_rdata,
  output logic [pNUM_TARGETS-1:0]           tgt_cen,
  output logic [pNUM_TARGETS-1:0]           tgt_rdn,
  output logic [pNUM_TARGETS-1:0]           tgt_wrn,
  output logic                              busy,
  output logic                              error
);
  localparam int LW = pADDR_WIDTH - pSEL_BITS;
  localparam logic [pSEL_BITS-1:0] SEL_RSVD = '1;

  typedef enum logic [1:0] {IDLE, WRITE, READ, HOLD} state_t;

  state_t                            state, state_nxt;
  logic   [pSEL_BITS-1:0]            sel_q;
  logic   [3:0]                      cnt;
  logic                              rd_req, wr_req, bad_req;
  logic                              sel_ok, sel_rsvd, rd_last;
  logic                              err_set, err_clr;
  logic   [7:0]                      rd_byte;
  logic   [pNUM_TARGETS-1:0][7:0]    rdata_v;
  logic   [pNUM_TARGETS-1:0]         wr_act, rd_act;

  assign rdata_v  = tgt_rdata;
  assign rd_req   = ~host_cen & ~host_rdn &  host_wrn;
  assign wr_req   = ~host_cen &  host_rdn & ~host_wrn;
  assign bad_req  = ~host_cen & ~host_rdn & ~host_wrn;
  assign sel_ok   = (32'(sel_q) < pNUM_TARGETS);
  assign sel_rsvd = (sel_q == SEL_RSVD);
  assign rd_last  = (cnt == 4'(pRD_LATENCY - 1));
  assign busy     = (state != IDLE);

  always_comb begin
    rd_byte = '0;
    for (int n = 0; n < pNUM_TARGETS; n++)
      if (sel_q == pSEL_BITS'(n)) rd_byte = rdata_v[n];
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (bad_req) state_nxt = HOLD;
             else if (wr_req) state_nxt = WRITE;
             else if (rd_req) state_nxt = READ;
      WRITE: state_nxt = HOLD;
      READ:  if (rd_last) state_nxt = HOLD;
      HOLD:  if (host_rdn && host_wrn) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Set beats clear if both ever land on the same edge.
  assign err_set = (state == IDLE  && bad_req) ||
                   (state == WRITE && !sel_ok && !sel_rsvd) ||
                   (state == READ  && rd_last && !sel_ok && !sel_rsvd);
  assign err_clr = (state == WRITE) && sel_rsvd;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      sel_q      <= '0;
      cnt        <= '0;
      tgt_addr   <= '0;
      tgt_wdata  <= '0;
      host_rdata <= '0;
      error      <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (rd_req || wr_req) begin
          sel_q     <= host_addr[pADDR_WIDTH-1 -: pSEL_BITS];
          tgt_addr  <= host_addr[LW-1:0];
          tgt_wdata <= host_wdata;
          cnt       <= '0;
        end
        READ: begin
          cnt <= cnt + 4'd1;
          if (rd_last)
            host_rdata <= sel_ok ? rd_byte : (sel_rsvd ? {7'b0, error} : 8'hEE);
        end
        default: ;
      endcase
      if (err_set)      error <= 1'b1;
      else if (err_clr) error <= 1'b0;
    end
  end

  // Strobes decode straight from registered state, so only sel_q's channel can go low.
  for (genvar n = 0; n < pNUM_TARGETS; n++) begin : g_lane
    assign wr_act[n] = (state == WRITE) && (sel_q == pSEL_BITS'(n));
    assign rd_act[n] = (state == READ)  && (sel_q == pSEL_BITS'(n));
    ss2_target_lane u_lane (
      .wr_act (wr_act[n]),
      .rd_act (rd_act[n]),
      .cen    (tgt_cen[n]),
      .rdn    (tgt_rdn[n]),
      .wrn    (tgt_wrn[n])
    );
  end
endmodule

// File: tb/tb_ss2_target_mux.sv
// Bench for ss2_target_mux: directed plan steps then random accesses checked
// against a transaction-level model of the bridge.

module tb_ss2_target_mux;
  localparam int L = 2;

  logic        clk, resetn;
  logic [31:0] host_addr;
  logic [7:0]  host_wdata, host_rdata;
  logic        host_rdn, host_wrn, host_cen;
  logic [29:0] tgt_addr;
  logic [7:0]  tgt_wdata;
  logic [15:0] tgt_rdata;
  logic [1:0]  tgt_cen, tgt_rdn, tgt_wrn;
  logic        busy, error;

  int nchk = 0, nfail = 0;

  logic        m_err;
  logic [7:0]  m_rdata, m_wdata;
  logic [29:0] m_addr;

  ss2_target_mux #(.pADDR_WIDTH(32), .pSEL_BITS(2), .pNUM_TARGETS(2), .pRD_LATENCY(L)) dut (
    .clk(clk), .resetn(resetn), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_rdn(host_rdn), .host_wrn(host_wrn), .host_cen(host_cen),
    .tgt_addr(tgt_addr), .tgt_wdata(tgt_wdata), .tgt_rdata(tgt_rdata), .tgt_cen(tgt_cen),
    .tgt_rdn(tgt_rdn), .tgt_wrn(tgt_wrn), .busy(busy), .error(error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One host access: strobes held for 'hold' cycles, then released.
  // Observation i counts clock cycles after the edge that sampled the request.
  task automatic access(input logic [31:0] addr, input logic [7:0] wd, input bit rd,
                        input bit wr, input int hold, input logic [15:0] rdat);
    int          wcnt[2], rcnt[2], ccnt[2], first[2];
    int          e_w[2], e_r[2], e_first[2];
    int          multi, sel;
    logic        busy1;
    logic [29:0] e_addr;
    sel = int'(addr[31:30]);
    for (int n = 0; n < 2; n++) begin
      wcnt[n] = 0; rcnt[n] = 0; ccnt[n] = 0; first[n] = 0;
      e_w[n] = 0; e_r[n] = 0; e_first[n] = 0;
    end
    multi = 0;
    busy1 = 1'b0;

    if (rd && wr) m_err = 1'b1;
    else begin
      m_addr  = addr[29:0];
      m_wdata = wd;
      if (sel < 2) begin
        e_first[sel] = 1;
        if (wr) e_w[sel] = 1; else e_r[sel] = L;
      end
      if (wr) begin
        if (sel == 3) m_err = 1'b0;
        else if (sel == 2) m_err = 1'b1;
      end else begin
        if (sel < 2) m_rdata = rdat[8*sel +: 8];
        else if (sel == 3) m_rdata = {7'b0, m_err};
        else begin m_rdata = 8'hEE; m_err = 1'b1; end
      end
    end
    e_addr = m_addr;

    host_addr = addr; host_wdata = wd; tgt_rdata = rdat;
    host_cen = 1'b0; host_rdn = !rd; host_wrn = !wr;
    for (int i = 1; i <= hold; i++) begin
      @(negedge clk);
      if (i == 1) busy1 = busy;
      if ((2 - $countones(tgt_cen)) > 1) multi++;
      for (int n = 0; n < 2; n++) begin
        if (!tgt_wrn[n]) wcnt[n]++;
        if (!tgt_rdn[n]) rcnt[n]++;
        if (!tgt_cen[n]) begin
          ccnt[n]++;
          if (first[n] == 0) first[n] = i;
        end
      end
    end
    host_rdn = 1'b1; host_wrn = 1'b1; host_cen = 1'b1;
    @(negedge clk);
    chk("busy_after_release", {31'b0, busy}, 32'd0);
    chk("busy_at_T1", {31'b0, busy1}, 32'd1);
    chk("one_channel_low", multi, 0);
    for (int n = 0; n < 2; n++) begin
      chk($sformatf("wrn_pulses[%0d]", n), wcnt[n], e_w[n]);
      chk($sformatf("rdn_cycles[%0d]", n), rcnt[n], e_r[n]);
      chk($sformatf("cen_cycles[%0d]", n), ccnt[n], e_w[n] + e_r[n]);
      chk($sformatf("first_low[%0d]", n), first[n], e_first[n]);
    end
    chk("host_rdata", {24'b0, host_rdata}, {24'b0, m_rdata});
    chk("error", {31'b0, error}, {31'b0, m_err});
    chk("tgt_addr", {2'b0, tgt_addr}, {2'b0, e_addr});
    chk("tgt_wdata", {24'b0, tgt_wdata}, {24'b0, m_wdata});
  endtask

  initial begin
    resetn = 1'b0; host_addr = '0; host_wdata = '0; tgt_rdata = '0;
    host_rdn = 1'b1; host_wrn = 1'b1; host_cen = 1'b1;
    m_err = 1'b0; m_rdata = '0; m_wdata = '0; m_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_strobes", {26'b0, tgt_cen, tgt_rdn, tgt_wrn}, 32'h3F);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_error", {31'b0, error}, 32'd0);
    chk("rst_rdata", {24'b0, host_rdata}, 32'd0);
    chk("rst_tgt_addr", {2'b0, tgt_addr}, 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    access(32'h0000_0010, 8'hA5, 1'b0, 1'b1, 6, 16'h0000);
    access(32'h4000_0004, 8'h00, 1'b1, 1'b0, 5, 16'h3C77);
    access(32'h8000_0000, 8'h00, 1'b1, 1'b0, 5, 16'h1234);
    access(32'hC000_0000, 8'h00, 1'b1, 1'b0, 5, 16'h1234);
    access(32'hC000_0000, 8'h5A, 1'b0, 1'b1, 4, 16'h0000);
    access(32'hC000_0000, 8'h00, 1'b1, 1'b0, 5, 16'h0000);
    access(32'h0000_0001, 8'h11, 1'b1, 1'b1, 5, 16'h0000);
    access(32'h4000_0002, 8'h99, 1'b0, 1'b1, 20, 16'h0000);
    access(32'h8000_0003, 8'h42, 1'b0, 1'b1, 4, 16'h0000);
    access(32'h0000_00FF, 8'h00, 1'b1, 1'b0, 4, 16'hBEEF);

    for (int k = 0; k < 80; k++) begin
      int          kind;
      logic [31:0] lo;
      logic [1:0]  s;
      kind = int'($urandom_range(0, 9));
      s    = 2'($urandom_range(0, 3));
      lo   = $urandom;
      access({s, lo[29:0]}, 8'($urandom), kind >= 5 || kind == 0, kind <= 4,
             int'($urandom_range(L + 2, 12)), 16'($urandom));
    end

    // Reset during the first READ cycle with error already set.
    access(32'h8000_0000, 8'h00, 1'b1, 1'b0, 5, 16'h0000);
    host_addr = 32'h0000_0008; tgt_rdata = 16'h00AA;
    host_cen = 1'b0; host_rdn = 1'b0; host_wrn = 1'b1;
    @(negedge clk);
    chk("mid_read_rdn0", {31'b0, tgt_rdn[0]}, 32'd0);
    resetn = 1'b0; host_cen = 1'b1; host_rdn = 1'b1;
    @(negedge clk);
    chk("mrst_strobes", {26'b0, tgt_cen, tgt_rdn, tgt_wrn}, 32'h3F);
    chk("mrst_busy", {31'b0, busy}, 32'd0);
    chk("mrst_rdata", {24'b0, host_rdata}, 32'd0);
    chk("mrst_error", {31'b0, error}, 32'd0);
    resetn = 1'b1;
    m_err = 1'b0; m_rdata = '0; m_wdata = '0; m_addr = '0;
    @(negedge clk);
    access(32'h4000_0001, 8'h00, 1'b1, 1'b0, 4, 16'h6600);

    $display("%0d/%0d checks passed", nchk - nfail, nchk);
    $finish;
  end
endmodule
